mem_access_unit: RTL and testbench



---
 rtl/mem_access_unit.sv | 132 +++++++++++++
 tb/tb_mem_access_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// Purpose : single-outstanding CPU load/store front end to a req/ack memory port, with timeout abort.
// Latency : done two cycles after start at best (ack in the first REQ cycle); aborts after TIMEOUT+1 unacked REQ cycles.
// Backpr. : start is only sampled in IDLE; while busy, further starts are dropped, not queued.
module mem_access_unit #(
  parameter int N       = 16,
  parameter int A       = 8,
  parameter int TIMEOUT = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         we,
  input  logic [A-1:0] addr,
  input  logic [N-1:0] Data_write,
  output logic [N-1:0] Data_out,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic         mem_req,
  output logic         mem_we,
  output logic [A-1:0] mem_addr,
  output logic [N-1:0] mem_wdata,
  input  logic [N-1:0] mem_rdata,
  input  logic         mem_ack
);

  // Wide enough to hold TIMEOUT itself, so the compare never sees a wrapped value.
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   dout_q, dout_d;
  logic           done_q, done_d;
  logic           err_q, err_d;
  logic           req_q, req_d;
  logic           we_q, we_d;
  logic [A-1:0]   addr_q, addr_d;
  logic [N-1:0]   wdata_q, wdata_d;

  logic           timed_out;
  assign timed_out = (cnt_q == CW'(TIMEOUT));

  // Next-state and registered-output logic; ack takes priority over the timeout check.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    dout_d  = dout_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    req_d   = req_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          we_d    = we;
          addr_d  = addr;
          wdata_d = Data_write;
          cnt_d   = '0;
          req_d   = 1'b1;
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          if (!we_q) begin
            dout_d = mem_rdata;
          end
          req_d   = 1'b0;
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (timed_out) begin
          req_d   = 1'b0;
          done_d  = 1'b1;
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        req_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State register with synchronous active-low reset clearing every output.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      dout_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dout_q  <= dout_d;
      done_q  <= done_d;
      err_q   <= err_d;
      req_q   <= req_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign Data_out  = dout_q;
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  assign err       = err_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  localparam int N  = 16;
  localparam int A  = 8;
  localparam int TO = 15;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic         we;
  logic [A-1:0] addr;
  logic [N-1:0] Data_write;
  logic [N-1:0] Data_out;
  logic         busy, done, err;
  logic         mem_req, mem_we;
  logic [A-1:0] mem_addr;
  logic [N-1:0] mem_wdata;
  logic [N-1:0] mem_rdata;
  logic         mem_ack;

  int checks   = 0;
  int failures = 0;
  logic [N-1:0] exp_dout;

  mem_access_unit #(.N(N), .A(A), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .we         (we),
    .addr       (addr),
    .Data_write (Data_write),
    .Data_out   (Data_out),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ack    (mem_ack)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One access from an IDLE cycle. ack_k = index of the REQ cycle carrying mem_ack
  // (values above TO mean no ack). inject pulses a stray start with addr 0x99 mid-REQ.
  task automatic run_txn(input logic w, input logic [A-1:0] a, input logic [N-1:0] wd,
                         input int ack_k, input logic [N-1:0] rd, input bit inject);
    int  end_r;
    bit  exp_err;
    exp_err = (ack_k > TO);
    end_r   = exp_err ? TO : ack_k;
    start = 1'b1; we = w; addr = a; Data_write = wd;
    step();
    start = 1'b0; addr = $urandom; Data_write = $urandom; we = $urandom;
    for (int r = 0; r <= TO; r++) begin
      chk("req_high", mem_req, 1);
      chk("req_addr", mem_addr, a);
      chk("req_we", mem_we, w);
      chk("req_wdata", mem_wdata, wd);
      chk("req_nodone", done, 0);
      if (r == ack_k) begin
        mem_ack = 1'b1; mem_rdata = rd;
      end else begin
        mem_ack = 1'b0; mem_rdata = $urandom;
      end
      if (inject && r == 1) begin
        start = 1'b1; addr = 8'h99; we = ~w;
      end
      step();
      mem_ack = 1'b0; start = 1'b0;
      if (r == end_r) break;
    end
    if (!w && !exp_err) exp_dout = rd;
    chk("done_pulse", done, 1);
    chk("done_err", err, exp_err);
    chk("done_req_low", mem_req, 0);
    chk("done_busy", busy, 1);
    chk("done_dout", Data_out, exp_dout);
    step();
    chk("idle_done_low", done, 0);
    chk("idle_err_low", err, 0);
    chk("idle_busy", busy, 0);
    chk("idle_req", mem_req, 0);
    chk("idle_dout", Data_out, exp_dout);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; we = 1'b0; addr = '0; Data_write = '0;
    mem_rdata = '0; mem_ack = 1'b0; exp_dout = '0;

    // Reset state, with start asserted during reset (must not be accepted).
    step();
    start = 1'b1; addr = 8'h55;
    step();
    step();
    chk("rst_busy", busy, 0);
    chk("rst_req", mem_req, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    chk("rst_dout", Data_out, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wdata, 0);
    chk("rst_we", mem_we, 0);
    start = 1'b0;
    rst_n = 1'b1;
    step();
    chk("post_rst_idle", busy, 0);

    // Minimum-latency load.
    run_txn(1'b0, 8'h12, 16'h0000, 0, 16'hBEEF, 1'b0);
    // Store, ack three cycles late: request held four cycles, Data_out kept.
    run_txn(1'b1, 8'h40, 16'h1234, 3, 16'hDEAD, 1'b0);
    // Timeout with no ack.
    run_txn(1'b0, 8'h21, 16'h0000, TO + 5, 16'h7777, 1'b0);
    // Ack exactly on the timeout cycle wins.
    run_txn(1'b0, 8'h22, 16'h0000, TO, 16'hA5C3, 1'b0);
    // Stray start during REQ is ignored.
    run_txn(1'b0, 8'h33, 16'h0000, 4, 16'h4321, 1'b1);

    // mem_ack in IDLE is ignored.
    mem_ack = 1'b1; mem_rdata = 16'hFFFF;
    step();
    mem_ack = 1'b0;
    chk("idle_ack_done", done, 0);
    chk("idle_ack_dout", Data_out, exp_dout);
    chk("idle_ack_busy", busy, 0);

    // Randomised accesses, including back-to-back starts.
    for (int i = 0; i < 24; i++) begin
      run_txn(1'($urandom), A'($urandom), N'($urandom), int'($urandom_range(0, TO + 2)),
              N'($urandom), 1'($urandom_range(0, 3) == 0));
    end

    // Reset in mid-REQ, then a late ack.
    start = 1'b1; we = 1'b0; addr = 8'h77;
    step();
    start = 1'b0;
    step();
    step();
    chk("midreq_req", mem_req, 1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_dout = '0;
    chk("rst_mid_req", mem_req, 0);
    chk("rst_mid_done", done, 0);
    chk("rst_mid_dout", Data_out, 0);
    chk("rst_mid_busy", busy, 0);
    mem_ack = 1'b1; mem_rdata = 16'h9999;
    step();
    mem_ack = 1'b0;
    chk("late_ack_done", done, 0);
    chk("late_ack_dout", Data_out, 0);
    chk("late_ack_busy", busy, 0);
    chk("late_ack_req", mem_req, 0);

    // Block still works after the reset.
    run_txn(1'b0, 8'h5A, 16'h0000, 1, 16'h0F0F, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
